// File: rtl/cmp_pkg.sv
// Relation encoding shared by the comparator debounce monitor and its event slot.
// flags_to_rel collapses the comparator's gt/lt/eq flags into one relation code.
package cmp_pkg;

  typedef enum logic [1:0] {
    REL_LT  = 2'd0,
    REL_EQ  = 2'd1,
    REL_GT  = 2'd2,
    REL_UNK = 2'd3
  } rel_e;

  // Anything other than exactly one flag set maps to UNK.
  function automatic rel_e flags_to_rel(input logic gt, input logic lt, input logic eq);
    rel_e rel;
    case ({gt, lt, eq})
      3'b100:  rel = REL_GT;
      3'b010:  rel = REL_LT;
      3'b001:  rel = REL_EQ;
      default: rel = REL_UNK;
    endcase
    return rel;
  endfunction

endpackage

// File: rtl/cmp_debounce_monitor_if.sv
// Sample input bus and event valid/ready handshake of the debounce monitor.
// The monitor uses the slave modport; the sample source and event sink use master.
interface cmp_debounce_monitor_if;
  logic       i_valid;
  logic       i_gt;
  logic       i_lt;
  logic       i_eq;
  logic       o_evt_valid;
  logic       i_evt_ready;
  logic [1:0] o_evt_code;
  logic [1:0] o_evt_prev;

  modport slave (
    input  i_valid, i_gt, i_lt, i_eq, i_evt_ready,
    output o_evt_valid, o_evt_code, o_evt_prev
  );

  modport master (
    output i_valid, i_gt, i_lt, i_eq, i_evt_ready,
    input  o_evt_valid, o_evt_code, o_evt_prev
  );
endinterface

// File: rtl/cmp_evt_slot.sv
// One-entry valid/ready event register. A new event arriving while the entry is
// full and not being drained is dropped and latches the sticky overrun flag.
module cmp_evt_slot
  import cmp_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_load,
  input  rel_e       i_code,
  input  rel_e       i_prev,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [1:0] o_code,
  output logic [1:0] o_prev,
  output logic       o_overrun
);

  logic r_valid;
  logic r_overrun;
  rel_e r_code;
  rel_e r_prev;
  logic w_drain;
  logic w_accept;

  // Draining and reloading in the same cycle keeps valid high with no bubble.
  assign w_drain  = r_valid & i_ready;
  assign w_accept = i_load & (~r_valid | w_drain);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid   <= 1'b0;
      r_code    <= REL_UNK;
      r_prev    <= REL_UNK;
      r_overrun <= 1'b0;
    end else if (w_accept) begin
      r_valid <= 1'b1;
      r_code  <= i_code;
      r_prev  <= i_prev;
    end else if (i_load) begin
      r_overrun <= 1'b1;
    end else if (w_drain) begin
      r_valid <= 1'b0;
    end
  end

  assign o_valid   = r_valid;
  assign o_code    = r_code;
  assign o_prev    = r_prev;
  assign o_overrun = r_overrun;

endmodule

// File: rtl/cmp_debounce_monitor.sv
// Debounces the 4-bit comparator's relation flags into a stable relation and
// reports each stable-state change as an event, counting commits.
module cmp_debounce_monitor
  import cmp_pkg::*;
#(
  parameter int DEBOUNCE  = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  cmp_debounce_monitor_if.slave bus,
  output logic [1:0]           o_state,
  output logic [CNT_WIDTH-1:0] o_evt_cnt,
  output logic                 o_illegal,
  output logic                 o_overrun
);

  localparam int RUN_W = $clog2(DEBOUNCE + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(DEBOUNCE);

  rel_e                 r_state;
  rel_e                 w_state_next;
  rel_e                 r_cand;
  rel_e                 w_cand_next;
  rel_e                 w_rel;
  logic [RUN_W-1:0]     r_run;
  logic [RUN_W-1:0]     w_run_next;
  logic [CNT_WIDTH-1:0] r_evt_cnt;
  logic                 r_illegal;
  logic                 w_legal;
  logic                 w_illegal;
  logic                 w_commit;

  // Candidate run tracking; the run saturates so a held value never re-commits.
  always_comb begin
    w_rel       = flags_to_rel(bus.i_gt, bus.i_lt, bus.i_eq);
    w_legal     = bus.i_valid && (w_rel != REL_UNK);
    w_illegal   = bus.i_valid && (w_rel == REL_UNK);
    w_cand_next = r_cand;
    w_run_next  = r_run;
    if (w_illegal) begin
      w_cand_next = REL_UNK;
      w_run_next  = '0;
    end else if (w_legal) begin
      if (w_rel == r_cand) begin
        if (r_run != RUN_MAX) w_run_next = r_run + 1'b1;
      end else begin
        w_cand_next = w_rel;
        w_run_next  = RUN_W'(1);
      end
    end
  end

  // Stable-state FSM: leaves UNK on the first commit and never returns to it.
  always_comb begin
    w_commit     = w_legal && (w_run_next == RUN_MAX) && (w_cand_next != r_state);
    w_state_next = r_state;
    if (w_commit) w_state_next = w_cand_next;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= REL_UNK;
      r_cand    <= REL_UNK;
      r_run     <= '0;
      r_evt_cnt <= '0;
      r_illegal <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_cand    <= w_cand_next;
      r_run     <= w_run_next;
      r_illegal <= w_illegal;
      if (w_commit) r_evt_cnt <= r_evt_cnt + 1'b1;
    end
  end

  cmp_evt_slot u_evt_slot (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_load    (w_commit),
    .i_code    (w_cand_next),
    .i_prev    (r_state),
    .i_ready   (bus.i_evt_ready),
    .o_valid   (bus.o_evt_valid),
    .o_code    (bus.o_evt_code),
    .o_prev    (bus.o_evt_prev),
    .o_overrun (o_overrun)
  );

  assign o_state   = r_state;
  assign o_evt_cnt = r_evt_cnt;
  assign o_illegal = r_illegal;

endmodule
